w21_mac_c2: RTL and testbench
=============================

# w21_mac_c2

Sequential multiply-accumulate engine for column 2 of the W21 layer. It walks the 300-entry column ROM (`w21_rom_c2`, combinational, 9-bit address, 21-bit signed weight) in step with an incoming activation stream. It accumulates the 300 weight×activation products, then rounds and saturates the sum to a 21-bit fixed-point neuron output. The block sits directly downstream of the column ROM and upstream of the next-layer input buffer.

## Interface
Parameters:
- N_IN, 300, number of activation/weight pairs per neuron
- ADDR_W, 9, ROM address width
- D_W, 21, weight, activation and output width (two's complement)
- ACC_W, 51, accumulator width (2·D_W + ceil(log2 N_IN))
- FRAC, 10, fractional bits of activations and output

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one neuron evaluation (sampled only in IDLE)
- act_valid  in  1  activation beat valid
- act_ready  out  1  activation beat accepted when act_valid & act_ready
- act_data  in  D_W  signed activation, Q(D_W-FRAC).FRAC
- adrs_clm  out  ADDR_W  address to w21_rom_c2
- w_data  in  D_W  signed weight returned combinationally by the ROM
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  D_W  rounded, saturated neuron output
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: adrs_clm=0, act_ready=0. start=1 → clear accumulator and beat counter → RUN.
- RUN: act_ready=1. adrs_clm equals the beat index k (0..N_IN-1). On each accepted beat, prod_r <= act_data·w_data (signed, 2·D_W bits) and the prod_v flag is set. The counter increments. Gaps in act_valid insert bubbles (prod_v=0), with no accumulation.
- Accumulate stage: if prod_v, acc <= acc + sign-extended prod_r.
- Accepting beat N_IN-1 → DRAIN; act_ready drops the following cycle. Counter and adrs_clm never exceed N_IN-1.
- DRAIN, 2 cycles: flushes the product and accumulate stages, then loads out_data → DONE.
- Result computation: r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift). Clamp r to [-2^(D_W-1), 2^(D_W-1)-1].
- DONE: out_valid=1 and out_data stay stable until out_valid & out_ready, then → IDLE.
- start outside IDLE is ignored, including start in the same cycle as the output handshake.
- rst_n low at any time, mid-run included: immediate return to IDLE with all state cleared.

## Timing
- Reset values: act_ready=0, adrs_clm=0, out_valid=0, out_data=0, busy=0; accumulator and counter are 0.
- The start edge moves the FSM to RUN. act_ready is high from the next cycle.
- Pipeline: beat accepted at edge E0 → product registered at E1 → accumulated at E2.
- Final beat accepted at edge E0 → out_valid high after E3. Minimum latency from the first accept to out_valid is N_IN+2 edges (302).
- Throughput: one beat per cycle. Total per neuron is ≥ 304 cycles including the start and output handshake.
- w_data must be valid in the same cycle as adrs_clm; the ROM has no register.

## Configuration
- W21_MAC_RELU_EN defined: after rounding and saturation, negative results are forced to 0, so out_data ∈ [0, 2^(D_W-1)-1].
- Not defined: the signed saturated value is output unchanged.

## Structure
- Shared package nn_pkg holds:
  - D_W, FRAC, ACC_W and N_IN_L21 constants
  - the state enum type mac_state_t {IDLE, RUN, DRAIN, DONE}
- Sub-module w21_round_sat: combinational round-half-up, arithmetic shift and clamp (ACC_W in → D_W out). The ReLU option lives here.
- Top level: FSM, beat counter, product register, accumulator, output register.

## Test plan
- Real ROM, FRAC=10. act=1024 on beat 0 and 0 on all other beats → out_data=-115 (weight at address 0). With W21_MAC_RELU_EN → 0.
- act=1024 on beat 3 only → out_data=288. Add act=1024 on beat 1 as well → out_data=288-391=-103.
- act_valid toggled randomly, roughly 50%, with act=1024 only on beat 3:
  - result is still 288
  - adrs_clm advances only on accepted beats
  - out_valid comes exactly 3 edges after the last accept.
- Bench ROM stub returning constant 2^20-1, all acts = 2^20-1 → out_data=1048575 (positive saturation). With negated weights → -1048576.
- out_ready held low for 20 cycles in DONE:
  - out_data stable, no new accept
  - start pulses ignored
  - after the handshake, start is accepted and a second neuron evaluates correctly.
- rst_n asserted at beat 150:
  - all outputs at their reset values immediately
  - next start gives a result identical to a clean run.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and state type for the W21 layer MAC columns.
package nn_pkg;

   localparam int D_W      = 21;
   localparam int FRAC     = 10;
   localparam int N_IN_L21 = 300;
   localparam int ADDR_W   = 9;
   localparam int ACC_W    = 2 * D_W + $clog2(N_IN_L21);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mac_state_t;

endpackage

// File: rtl/w21_mac_c2_if.sv
// Start/activation/ROM/result signal bundle for the column-2 MAC engine.
interface w21_mac_c2_if;

   logic                               start;
   logic                               act_valid;
   logic                               act_ready;
   logic signed [nn_pkg::D_W-1:0]      act_data;
   logic        [nn_pkg::ADDR_W-1:0]   adrs_clm;
   logic signed [nn_pkg::D_W-1:0]      w_data;
   logic                               out_valid;
   logic                               out_ready;
   logic signed [nn_pkg::D_W-1:0]      out_data;
   logic                               busy;

   modport slave (
      input  start, act_valid, act_data, w_data, out_ready,
      output act_ready, adrs_clm, out_valid, out_data, busy
   );

   modport master (
      output start, act_valid, act_data, w_data, out_ready,
      input  act_ready, adrs_clm, out_valid, out_data, busy
   );

endinterface

// File: rtl/w21_round_sat.sv
// Round-half-up, arithmetic shift by FRAC and clamp of the accumulator to D_W bits.
// Optional W21_MAC_RELU_EN forces negative results to zero after the clamp.
module w21_round_sat
   import nn_pkg::*;
(
   input  logic signed [ACC_W-1:0] i_acc,
   output logic signed [D_W-1:0]   o_res
);

   localparam logic signed [ACC_W:0] RND    = {{(ACC_W+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W+2-D_W){1'b0}}, {(D_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W+2-D_W){1'b1}}, {(D_W-1){1'b0}}};

   logic signed [ACC_W:0] w_sum;
   logic signed [ACC_W:0] w_shr;
   logic signed [D_W-1:0] w_sat;

   // One guard bit so the rounding offset can never wrap the sum.
   assign w_sum = (ACC_W+1)'(i_acc) + RND;
   assign w_shr = w_sum >>> FRAC;

   always_comb begin
      w_sat = w_shr[D_W-1:0];
      if (w_shr > SAT_HI) begin
         w_sat = {1'b0, {(D_W-1){1'b1}}};
      end else if (w_shr < SAT_LO) begin
         w_sat = {1'b1, {(D_W-1){1'b0}}};
      end
   end

`ifdef W21_MAC_RELU_EN
   assign o_res = w_sat[D_W-1] ? '0 : w_sat;
`else
   assign o_res = w_sat;
`endif

endmodule

// File: rtl/w21_mac_c2.sv
// Column-2 W21 multiply-accumulate engine: walks the weight ROM in step with the
// activation stream, then rounds/saturates (ReLU with W21_MAC_RELU_EN) the sum.
//
// state | meaning
// IDLE  | waiting for start, address parked at 0
// RUN   | accepting activation beats, one per cycle when valid
// DRAIN | flushing product/accumulate stages, then loading the result
// DONE  | result held on out_data until out_ready
module w21_mac_c2
   import nn_pkg::*;
#(
   parameter int N_IN = N_IN_L21
)
(
   input  logic              clk,
   input  logic              rst_n,
   w21_mac_c2_if.slave       bus
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_RUN   = RUN;
   localparam logic [1:0] S_DRAIN = DRAIN;
   localparam logic [1:0] S_DONE  = DONE;

   logic [1:0]                r_state;
   logic [ADDR_W-1:0]         r_cnt;
   logic [1:0]                r_drain;
   logic signed [2*D_W-1:0]   r_prod;
   logic                      r_prod_v;
   logic signed [ACC_W-1:0]   r_acc;
   logic signed [D_W-1:0]     r_out;

   logic                      w_accept;
   logic signed [2*D_W-1:0]   w_prod;
   logic signed [D_W-1:0]     w_res;

   assign w_accept = (r_state == S_RUN) && bus.act_valid;
   assign w_prod   = (2*D_W)'(bus.act_data) * (2*D_W)'(bus.w_data);

   w21_round_sat u_round_sat (
      .i_acc (r_acc),
      .o_res (w_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_drain  <= '0;
         r_prod   <= '0;
         r_prod_v <= 1'b0;
         r_acc    <= '0;
         r_out    <= '0;
      end else begin
         r_prod_v <= w_accept;
         if (w_accept) begin
            r_prod <= w_prod;
         end
         if (r_prod_v) begin
            r_acc <= r_acc + ACC_W'(r_prod);
         end

         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (r_cnt == ADDR_W'(N_IN - 1)) begin
                     r_drain <= 2'd2;
                     r_state <= S_DRAIN;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            // Two flush cycles, then the terminal count loads the rounded result.
            S_DRAIN: begin
               if (r_drain == 2'd0) begin
                  r_out   <= w_res;
                  r_state <= S_DONE;
               end else begin
                  r_drain <= r_drain - 1'b1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.act_ready = (r_state == S_RUN);
   assign bus.adrs_clm  = r_cnt;
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.out_data  = r_out;
   assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_w21_mac_c2.sv
// Scoreboard bench for w21_mac_c2 with a local stand-in for the column-2 ROM.
module tb_w21_mac_c2;
   import nn_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   w21_mac_c2_if bus ();

   w21_mac_c2 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rom_mode = 0;
   int acts [N_IN_L21];
   int exp_q [$];
   int n_pass = 0;
   int n_total = 0;

   function automatic logic signed [D_W-1:0] rom_w(input logic [ADDR_W-1:0] a, input int mode);
      int v;
      if (mode == 1) begin
         v = 1048575;
      end else if (mode == 2) begin
         v = -1048575;
      end else begin
         case (a)
            9'd0:    v = -115;
            9'd1:    v = -391;
            9'd3:    v = 288;
            default: v = ((int'(a) * 37) % 500) - 250;
         endcase
      end
      return D_W'(v);
   endfunction

   assign bus.w_data = rom_w(bus.adrs_clm, rom_mode);

   function automatic int relu(input int v);
`ifdef W21_MAC_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
   endtask

   task automatic clear_acts();
      foreach (acts[i]) acts[i] = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_act_ready"}, int'(bus.act_ready), 0);
      check({tag, "_adrs_clm"},  int'(bus.adrs_clm),  0);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_out_data"},  int'(bus.out_data),  0);
      check({tag, "_busy"},      int'(bus.busy),      0);
   endtask

   // Runs one neuron up to out_valid (or aborts with reset at beat abort_at).
   task automatic run(input int expv, input bit rnd, input int abort_at);
      int k;
      int budget;
      int last_acc;
      int n;
      bit accepted;
      if (abort_at < 0) exp_q.push_back(relu(expv));
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      k = 0;
      budget = 0;
      last_acc = cyc;
      while (k < N_IN_L21 && budget < 5000) begin
         if (k == abort_at) begin
            bus.act_valid = 1'b0;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("midrun_reset");
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         bus.act_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.act_data  = D_W'(acts[k]);
         @(negedge clk);
         if (rnd) check("adrs_clm_beat", int'(bus.adrs_clm), k);
         accepted = bus.act_valid && bus.act_ready;
         @(posedge clk); #1;
         if (accepted) begin
            k++;
            last_acc = cyc;
         end
         budget++;
      end
      bus.act_valid = 1'b0;
      bus.act_data  = '0;
      if (k < N_IN_L21) check("beat_timeout", k, N_IN_L21);
      @(negedge clk);
      check("act_ready_drop", int'(bus.act_ready), 0);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("result_latency", cyc - last_acc, 3);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("return_idle", int'(bus.busy), 0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.act_valid = 1'b0;
      bus.act_data  = '0;
      bus.out_ready = 1'b1;
      clear_acts();

      fork
         forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) check("unexpected_result", int'(bus.out_data), -99999999);
               else check("out_data", int'(bus.out_data), exp_q.pop_front());
            end
         end
      join_none

      #22;
      check_reset_outputs("reset");
      #10 rst_n = 1'b1;

      // Unit activation on single beats picks out individual weights.
      clear_acts(); acts[0] = 1024;
      run(-115, 1'b0, -1); wait_idle();
      clear_acts(); acts[3] = 1024;
      run(288, 1'b0, -1); wait_idle();
      clear_acts(); acts[1] = 1024; acts[3] = 1024;
      run(-103, 1'b0, -1); wait_idle();
      clear_acts(); acts[1] = 512;
      run(-195, 1'b0, -1); wait_idle();

      // Bubbly activation stream.
      clear_acts(); acts[3] = 1024;
      run(288, 1'b1, -1); wait_idle();

      // Saturation at both rails.
      rom_mode = 1;
      foreach (acts[i]) acts[i] = 1048575;
      run(1048575, 1'b0, -1); wait_idle();
      rom_mode = 2;
      run(-1048576, 1'b0, -1); wait_idle();
      rom_mode = 0;

      // Result held while the consumer stalls; start pulses ignored.
      clear_acts(); acts[3] = 1024;
      bus.out_ready = 1'b0;
      run(288, 1'b0, -1);
      for (int i = 0; i < 20; i++) begin
         bus.start     = (i == 5 || i == 12);
         bus.act_valid = 1'b1;
         @(negedge clk);
         check("hold_out_valid", int'(bus.out_valid), 1);
         check("hold_out_data",  int'(bus.out_data), relu(288));
         check("hold_act_ready", int'(bus.act_ready), 0);
         @(posedge clk); #1;
      end
      bus.act_valid = 1'b0;
      bus.start     = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("start_on_handshake_ignored", int'(bus.busy), 0);
      clear_acts(); acts[1] = 1024; acts[3] = 1024;
      run(-103, 1'b0, -1); wait_idle();

      // Reset mid-run, then a clean rerun.
      run(0, 1'b0, 150);
      @(negedge clk);
      check("after_reset_busy", int'(bus.busy), 0);
      run(-103, 1'b0, -1); wait_idle();

      repeat (5) @(posedge clk);
      check("pending_results", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
